// File: rtl/saturn_bus_arbiter.sv
// Two-requester (CPU, debugger) nibble-bus arbiter driven by an external one-hot 4-phase bus cycle.
// Optional build macro SATURN_ARB_RR_EN: round-robin tie-break instead of fixed debugger priority.
module saturn_bus_arbiter (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clk_en,
    input  logic [3:0] i_phases,
    input  logic       i_cpu_req,
    input  logic       i_dbg_req,
    input  logic       i_cpu_valid,
    input  logic       i_dbg_valid,
    input  logic [4:0] i_cpu_data,
    input  logic [4:0] i_dbg_data,
    output logic       o_cpu_pop,
    output logic       o_dbg_pop,
    output logic       o_cpu_grant,
    output logic       o_dbg_grant,
    output logic       o_cpu_rd_valid,
    output logic       o_dbg_rd_valid,
    output logic [3:0] o_rd_nibble,
    input  logic [3:0] i_bus_nibble_in,
    output logic       o_bus_clk_en,
    output logic       o_bus_is_data,
    output logic [3:0] o_bus_nibble_out,
    output logic       o_busy
);

    // Handshake: the owner presents i_x_valid/i_x_data; the entry is taken on the
    // enabled 0001 edge and o_x_pop is high for the following enabled cycle only.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN_CPU = 2'd1,
        ST_OWN_DBG = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_is_read;
    logic       r_rd_owner_dbg;
    logic       r_cpu_pop;
    logic       r_dbg_pop;
    logic       r_cpu_rd_valid;
    logic       r_dbg_rd_valid;
    logic [3:0] r_rd_nibble;
    logic       r_bus_clk_en;
    logic       r_bus_is_data;
    logic [3:0] r_bus_nibble_out;
`ifdef SATURN_ARB_RR_EN
    logic       r_last_dbg;
`endif

    state_t     w_arb_state;
    logic       w_owner_keeps;
    logic       w_own_valid;
    logic [4:0] w_own_data;

    always_comb begin
        w_owner_keeps = ((r_state == ST_OWN_CPU) && i_cpu_req) ||
                        ((r_state == ST_OWN_DBG) && i_dbg_req);
        w_arb_state   = ST_IDLE;
        if (w_owner_keeps) begin
            w_arb_state = r_state;
`ifdef SATURN_ARB_RR_EN
        end else if (i_dbg_req && i_cpu_req) begin
            w_arb_state = r_last_dbg ? ST_OWN_CPU : ST_OWN_DBG;
`endif
        end else if (i_dbg_req) begin
            w_arb_state = ST_OWN_DBG;
        end else if (i_cpu_req) begin
            w_arb_state = ST_OWN_CPU;
        end
    end

    always_comb begin
        w_own_valid = 1'b0;
        w_own_data  = 5'd0;
        if (r_state == ST_OWN_CPU) begin
            w_own_valid = i_cpu_valid;
            w_own_data  = i_cpu_data;
        end else if (r_state == ST_OWN_DBG) begin
            w_own_valid = i_dbg_valid;
            w_own_data  = i_dbg_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= ST_IDLE;
            r_is_read        <= 1'b0;
            r_rd_owner_dbg   <= 1'b0;
            r_cpu_pop        <= 1'b0;
            r_dbg_pop        <= 1'b0;
            r_cpu_rd_valid   <= 1'b0;
            r_dbg_rd_valid   <= 1'b0;
            r_rd_nibble      <= 4'd0;
            r_bus_clk_en     <= 1'b0;
            r_bus_is_data    <= 1'b0;
            r_bus_nibble_out <= 4'd0;
`ifdef SATURN_ARB_RR_EN
            r_last_dbg       <= 1'b0;
`endif
        end else if (i_clk_en) begin
            r_cpu_pop      <= 1'b0;
            r_dbg_pop      <= 1'b0;
            r_cpu_rd_valid <= 1'b0;
            r_dbg_rd_valid <= 1'b0;
            case (i_phases)
                4'b0001: begin
                    if (r_state != ST_IDLE) begin
                        r_bus_clk_en   <= 1'b1;
                        r_rd_owner_dbg <= (r_state == ST_OWN_DBG);
                        if (w_own_valid) begin
                            r_bus_nibble_out <= w_own_data[3:0];
                            r_bus_is_data    <= ~w_own_data[4];
                            r_is_read        <= 1'b0;
                            r_cpu_pop        <= (r_state == ST_OWN_CPU);
                            r_dbg_pop        <= (r_state == ST_OWN_DBG);
                        end else begin
                            r_bus_is_data <= 1'b1;
                            r_is_read     <= 1'b1;
                        end
                    end else begin
                        r_is_read <= 1'b0;
                    end
                end
                4'b0010: begin
                    r_bus_clk_en <= 1'b0;
                    if (r_is_read) begin
                        r_rd_nibble    <= i_bus_nibble_in;
                        r_cpu_rd_valid <= ~r_rd_owner_dbg;
                        r_dbg_rd_valid <= r_rd_owner_dbg;
                        r_is_read      <= 1'b0;
                    end
                end
                4'b1000: begin
                    // Ownership changes here so the new owner drives from the next 0001.
                    r_state <= w_arb_state;
`ifdef SATURN_ARB_RR_EN
                    if (w_arb_state == ST_OWN_CPU) begin
                        r_last_dbg <= 1'b0;
                    end else if (w_arb_state == ST_OWN_DBG) begin
                        r_last_dbg <= 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign o_cpu_grant      = (r_state == ST_OWN_CPU);
    assign o_dbg_grant      = (r_state == ST_OWN_DBG);
    assign o_busy           = (r_state != ST_IDLE);
    assign o_cpu_pop        = r_cpu_pop;
    assign o_dbg_pop        = r_dbg_pop;
    assign o_cpu_rd_valid   = r_cpu_rd_valid;
    assign o_dbg_rd_valid   = r_dbg_rd_valid;
    assign o_rd_nibble      = r_rd_nibble;
    assign o_bus_clk_en     = r_bus_clk_en;
    assign o_bus_is_data    = r_bus_is_data;
    assign o_bus_nibble_out = r_bus_nibble_out;

endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// Directed bench for saturn_bus_arbiter; the bench steps the bus phase explicitly each clock.
module tb_saturn_bus_arbiter;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_clk_en = 1'b1;
    logic [3:0] i_phases = 4'b0000;
    logic       i_cpu_req = 1'b0;
    logic       i_dbg_req = 1'b0;
    logic       i_cpu_valid = 1'b0;
    logic       i_dbg_valid = 1'b0;
    logic [4:0] i_cpu_data = 5'd0;
    logic [4:0] i_dbg_data = 5'd0;
    logic [3:0] i_bus_nibble_in = 4'd0;
    logic       o_cpu_pop, o_dbg_pop, o_cpu_grant, o_dbg_grant;
    logic       o_cpu_rd_valid, o_dbg_rd_valid, o_bus_clk_en, o_bus_is_data, o_busy;
    logic [3:0] o_rd_nibble, o_bus_nibble_out;

    int checks = 0;
    int errors = 0;

    saturn_bus_arbiter dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en), .i_phases(i_phases),
        .i_cpu_req(i_cpu_req), .i_dbg_req(i_dbg_req),
        .i_cpu_valid(i_cpu_valid), .i_dbg_valid(i_dbg_valid),
        .i_cpu_data(i_cpu_data), .i_dbg_data(i_dbg_data),
        .o_cpu_pop(o_cpu_pop), .o_dbg_pop(o_dbg_pop),
        .o_cpu_grant(o_cpu_grant), .o_dbg_grant(o_dbg_grant),
        .o_cpu_rd_valid(o_cpu_rd_valid), .o_dbg_rd_valid(o_dbg_rd_valid),
        .o_rd_nibble(o_rd_nibble), .i_bus_nibble_in(i_bus_nibble_in),
        .o_bus_clk_en(o_bus_clk_en), .o_bus_is_data(o_bus_is_data),
        .o_bus_nibble_out(o_bus_nibble_out), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // One clock with the given phase; outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic [3:0] ph);
        i_phases = ph;
        @(posedge i_clk);
        #1;
    endtask

    task automatic bus_cycle();
        tick(4'b0001); tick(4'b0010); tick(4'b0100); tick(4'b1000);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick(4'b0001); tick(4'b0010);
        i_reset = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", o_busy); end
        checks++; if ({o_cpu_grant, o_dbg_grant} !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", {o_cpu_grant, o_dbg_grant}); end
        checks++; if ({o_bus_clk_en, o_bus_is_data} !== 2'b00) begin errors++; $display("FAIL rst_strobe_isdata got %b exp 00", {o_bus_clk_en, o_bus_is_data}); end
        checks++; if ({o_bus_nibble_out, o_rd_nibble} !== 8'h00) begin errors++; $display("FAIL rst_nibbles got %h exp 00", {o_bus_nibble_out, o_rd_nibble}); end
        checks++; if ({o_cpu_pop, o_dbg_pop, o_cpu_rd_valid, o_dbg_rd_valid} !== 4'b0000) begin errors++; $display("FAIL rst_pulses got %b exp 0000", {o_cpu_pop, o_dbg_pop, o_cpu_rd_valid, o_dbg_rd_valid}); end
    endtask

    task automatic test_write();
        i_cpu_req = 1'b1; i_cpu_valid = 1'b1; i_cpu_data = 5'b10011;
        tick(4'b0001);
        checks++; if ({o_bus_clk_en, o_cpu_pop} !== 2'b00) begin errors++; $display("FAIL wr_idle_nostrobe got %b exp 00", {o_bus_clk_en, o_cpu_pop}); end
        tick(4'b0010); tick(4'b0100); tick(4'b1000);
        checks++; if ({o_cpu_grant, o_dbg_grant, o_busy} !== 3'b101) begin errors++; $display("FAIL wr_grant got %b exp 101", {o_cpu_grant, o_dbg_grant, o_busy}); end
        tick(4'b0001);
        i_cpu_valid = 1'b0;
        checks++; if ({o_bus_clk_en, o_bus_is_data} !== 2'b10) begin errors++; $display("FAIL wr_strobe_cmd got %b exp 10", {o_bus_clk_en, o_bus_is_data}); end
        checks++; if (o_bus_nibble_out !== 4'h3) begin errors++; $display("FAIL wr_nibble got %h exp 3", o_bus_nibble_out); end
        checks++; if ({o_cpu_pop, o_dbg_pop} !== 2'b10) begin errors++; $display("FAIL wr_pop got %b exp 10", {o_cpu_pop, o_dbg_pop}); end
        tick(4'b0010);
        checks++; if ({o_bus_clk_en, o_cpu_pop, o_cpu_rd_valid} !== 3'b000) begin errors++; $display("FAIL wr_end got %b exp 000", {o_bus_clk_en, o_cpu_pop, o_cpu_rd_valid}); end
        tick(4'b0100); tick(4'b1000);
    endtask

    task automatic test_read();
        i_bus_nibble_in = 4'hA;
        tick(4'b0001);
        checks++; if ({o_bus_clk_en, o_bus_is_data, o_cpu_pop} !== 3'b110) begin errors++; $display("FAIL rd_strobe got %b exp 110", {o_bus_clk_en, o_bus_is_data, o_cpu_pop}); end
        checks++; if (o_bus_nibble_out !== 4'h3) begin errors++; $display("FAIL rd_nibble_hold got %h exp 3", o_bus_nibble_out); end
        tick(4'b0010);
        checks++; if (o_rd_nibble !== 4'hA) begin errors++; $display("FAIL rd_data got %h exp a", o_rd_nibble); end
        checks++; if ({o_cpu_rd_valid, o_dbg_rd_valid, o_bus_clk_en, o_cpu_pop} !== 4'b1000) begin errors++; $display("FAIL rd_valid got %b exp 1000", {o_cpu_rd_valid, o_dbg_rd_valid, o_bus_clk_en, o_cpu_pop}); end
        tick(4'b0100);
        checks++; if (o_cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got %0b exp 0", o_cpu_rd_valid); end
        tick(4'b1000);
    endtask

    task automatic test_handover();
        i_cpu_valid = 1'b1; i_cpu_data = 5'h05; i_dbg_req = 1'b1;
        tick(4'b0001);
        checks++; if ({o_cpu_pop, o_bus_is_data, o_bus_nibble_out} !== 6'b11_0101) begin errors++; $display("FAIL ho_cpu_write got %b exp 110101", {o_cpu_pop, o_bus_is_data, o_bus_nibble_out}); end
        i_cpu_valid = 1'b0; i_cpu_req = 1'b0;
        tick(4'b0010);
        checks++; if ({o_cpu_grant, o_dbg_grant} !== 2'b10) begin errors++; $display("FAIL ho_drop_ignored got %b exp 10", {o_cpu_grant, o_dbg_grant}); end
        tick(4'b0100); tick(4'b1000);
        checks++; if ({o_cpu_grant, o_dbg_grant, o_busy} !== 3'b011) begin errors++; $display("FAIL ho_switch got %b exp 011", {o_cpu_grant, o_dbg_grant, o_busy}); end
        i_dbg_valid = 1'b1; i_dbg_data = 5'h1C;
        tick(4'b0001);
        i_dbg_valid = 1'b0;
        checks++; if ({o_dbg_pop, o_cpu_pop, o_bus_clk_en, o_bus_is_data} !== 4'b1010) begin errors++; $display("FAIL ho_dbg_cmd got %b exp 1010", {o_dbg_pop, o_cpu_pop, o_bus_clk_en, o_bus_is_data}); end
        checks++; if (o_bus_nibble_out !== 4'hC) begin errors++; $display("FAIL ho_dbg_nibble got %h exp c", o_bus_nibble_out); end
        tick(4'b0010); tick(4'b0100);
    endtask

    task automatic test_invalid_phase();
        i_dbg_valid = 1'b1; i_dbg_data = 5'h07; i_dbg_req = 1'b0;
        tick(4'b0011);
        checks++; if ({o_bus_clk_en, o_dbg_pop, o_bus_nibble_out} !== 6'b00_1100) begin errors++; $display("FAIL inv_0011 got %b exp 001100", {o_bus_clk_en, o_dbg_pop, o_bus_nibble_out}); end
        tick(4'b0000);
        checks++; if ({o_bus_clk_en, o_dbg_pop} !== 2'b00) begin errors++; $display("FAIL inv_0000 got %b exp 00", {o_bus_clk_en, o_dbg_pop}); end
        tick(4'b1001);
        checks++; if (o_dbg_grant !== 1'b1) begin errors++; $display("FAIL inv_no_arb got %0b exp 1", o_dbg_grant); end
        i_dbg_valid = 1'b0;
        tick(4'b1000);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL inv_release got %0b exp 0", o_busy); end
    endtask

    task automatic test_idle_ignore();
        i_cpu_valid = 1'b1; i_dbg_valid = 1'b1; i_bus_nibble_in = 4'h6;
        tick(4'b0001);
        checks++; if ({o_bus_clk_en, o_cpu_pop, o_dbg_pop} !== 3'b000) begin errors++; $display("FAIL idle_nostrobe got %b exp 000", {o_bus_clk_en, o_cpu_pop, o_dbg_pop}); end
        tick(4'b0010);
        checks++; if ({o_cpu_rd_valid, o_dbg_rd_valid, o_rd_nibble} !== 6'b00_1010) begin errors++; $display("FAIL idle_nord got %b exp 001010", {o_cpu_rd_valid, o_dbg_rd_valid, o_rd_nibble}); end
        i_cpu_valid = 1'b0; i_dbg_valid = 1'b0;
        tick(4'b0100); tick(4'b1000);
    endtask

    task automatic test_contention();
        logic [2:0] exp_dbg;
`ifdef SATURN_ARB_RR_EN
        exp_dbg = 3'b101;
`else
        exp_dbg = 3'b111;
`endif
        i_reset = 1'b1; tick(4'b0001); i_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_cpu_req = 1'b1; i_dbg_req = 1'b1;
            bus_cycle();
            checks++;
            if ({o_dbg_grant, o_cpu_grant} !== {exp_dbg[k], ~exp_dbg[k]}) begin
                errors++; $display("FAIL cont_grant_%0d got dbg/cpu %b exp %b", k, {o_dbg_grant, o_cpu_grant}, {exp_dbg[k], ~exp_dbg[k]});
            end
            i_cpu_req = 1'b0; i_dbg_req = 1'b0;
            bus_cycle();
            checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cont_release_%0d got %0b exp 0", k, o_busy); end
        end
    endtask

    task automatic test_reset_mid();
        i_cpu_req = 1'b1; i_cpu_valid = 1'b0; i_bus_nibble_in = 4'h5;
        bus_cycle();
        tick(4'b0001);
        checks++; if ({o_bus_clk_en, o_cpu_grant} !== 2'b11) begin errors++; $display("FAIL rm_strobe got %b exp 11", {o_bus_clk_en, o_cpu_grant}); end
        i_reset = 1'b1; i_cpu_req = 1'b0;
        tick(4'b0010);
        i_reset = 1'b0;
        checks++; if ({o_bus_clk_en, o_busy, o_cpu_rd_valid, o_cpu_pop} !== 4'b0000) begin errors++; $display("FAIL rm_abort got %b exp 0000", {o_bus_clk_en, o_busy, o_cpu_rd_valid, o_cpu_pop}); end
        checks++; if (o_rd_nibble !== 4'h0) begin errors++; $display("FAIL rm_rd_nibble got %h exp 0", o_rd_nibble); end
        tick(4'b0100); tick(4'b1000);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rm_idle got %0b exp 0", o_busy); end
    endtask

    task automatic test_clk_en();
        logic [3:0] frz_ph [3];
        frz_ph[0] = 4'b0010; frz_ph[1] = 4'b0100; frz_ph[2] = 4'b1000;
        i_cpu_req = 1'b1;
        bus_cycle();
        i_cpu_valid = 1'b1; i_cpu_data = 5'h09;
        tick(4'b0001);
        i_clk_en = 1'b0; i_cpu_req = 1'b0; i_dbg_req = 1'b1; i_cpu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(frz_ph[k]);
            checks++;
            if ({o_bus_clk_en, o_cpu_pop, o_cpu_grant, o_dbg_grant, o_bus_is_data, o_bus_nibble_out} !== 9'b1_1101_1001) begin
                errors++; $display("FAIL frz_hold_%0d got %b exp 111011001", k, {o_bus_clk_en, o_cpu_pop, o_cpu_grant, o_dbg_grant, o_bus_is_data, o_bus_nibble_out});
            end
        end
        i_clk_en = 1'b1;
        tick(4'b0010);
        checks++; if ({o_bus_clk_en, o_cpu_pop, o_cpu_grant} !== 3'b001) begin errors++; $display("FAIL frz_resume got %b exp 001", {o_bus_clk_en, o_cpu_pop, o_cpu_grant}); end
        tick(4'b0100); tick(4'b1000);
        checks++; if ({o_cpu_grant, o_dbg_grant} !== 2'b01) begin errors++; $display("FAIL frz_switch got %b exp 01", {o_cpu_grant, o_dbg_grant}); end
        i_clk_en = 1'b0; i_reset = 1'b1;
        tick(4'b0001);
        i_reset = 1'b0; i_clk_en = 1'b1; i_dbg_req = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL frz_reset_overrides got %0b exp 0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_handover();
        test_invalid_phase();
        test_idle_ignore();
        test_contention();
        test_reset_mid();
        test_clk_en();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
